alu_cmd_responder: RTL and testbench
====================================

Name: alu_cmd_responder

Overview:
- Sequential responder end of the ALU operand/opcode interface.
- Accepts one command (A, B, Opcode) per valid/ready handshake and executes it; logic ops take one cycle, MUL is a multi-cycle shift-add.
- Returns a 16-bit ALU_Out plus CarryOut and Err over a result valid/ready handshake, holding the result under backpressure.
- Sits between a command initiator (bench or sequencer) and downstream result consumers.

Parameters:
- WIDTH, 8: operand width. ALU_Out is 2*WIDTH. MUL and DIV each take WIDTH iterations.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Cmd_Valid  input  1  command present.
- Cmd_Ready  output  1  responder can accept a command.
- A  input  WIDTH  operand A, sampled at acceptance.
- B  input  WIDTH  operand B, sampled at acceptance.
- Opcode  input  5  operation select, sampled at acceptance.
- Res_Valid  output  1  result available.
- Res_Ready  input  1  consumer takes the result.
- ALU_Out  output  2*WIDTH  result.
- CarryOut  output  1  carry, borrow or shifted-out bit.
- Err  output  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. Cmd_Ready=0 while Reset_n=0 and 1 after release. Res_Valid=0, ALU_Out=0, CarryOut=0, Err=0. Any in-flight command is discarded.
- States and transitions:
  - IDLE: Cmd_Ready=1. On Cmd_Valid&&Cmd_Ready, latch A, B and Opcode, then go to EXEC (or MULT for MUL).
  - EXEC: compute at the next edge, go to DONE.
  - MULT: WIDTH shift-add iterations (one per clock), then DONE.
  - DONE: Res_Valid=1. On Res_Valid&&Res_Ready, go to IDLE.
- Cmd_Ready is 1 only in IDLE. A command and a result never complete on the same edge.
- Latency, counting edge e0 as the accepting edge:
  - Single-cycle ops: Res_Valid rises after e1.
  - MUL: Res_Valid rises after eWIDTH (e8 at the default width).
- While Res_Valid=1 and Res_Ready=0, ALU_Out, CarryOut and Err are held stable.
- Input changes after acceptance have no effect.
- Opcodes. Results narrower than 2*WIDTH are zero-extended. CarryOut=0 unless stated.
  - 0 ADD: A+B; CarryOut = bit WIDTH of the sum.
  - 1 SUB: A-B mod 2^WIDTH; CarryOut=1 if A<B.
  - 2 MUL: full 2*WIDTH product, unsigned.
  - 3 AND, 4 OR, 5 XOR.
  - 6 NOT: ~A.
  - 7 SHL: A<<1; CarryOut = A[MSB].
  - 8 SHR: A>>1; CarryOut = A[0].
  - 9 ROL, 10 ROR: rotate A by 1.
  - 11 CMP: bit0 = A==B, bit1 = A>B (unsigned).
  - Any other opcode: ALU_Out=0, CarryOut=0, Err=1, one-cycle path.
- Err=0 for all legal results.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: opcode 12 DIV runs as a WIDTH-iteration restoring division in a DIVS state, same latency as MUL.
  - Result: ALU_Out = {remainder, quotient}.
  - B==0: no iterations. ALU_Out = all ones, Err=1, Res_Valid after e1.
- Undefined: opcode 12 is illegal (ALU_Out=0, Err=1), and no DIVS state or divider logic exists.

Test Plan:
- ADD, A=8'hE7, B=8'h98, Res_Ready=1 -> Res_Valid after e1, ALU_Out=16'h007F, CarryOut=1, Err=0. Cmd_Ready back high the cycle after the result is taken.
- MUL, A=8'hE7, B=8'h98 -> ALU_Out=16'h8928 exactly 8 edges after acceptance. Cmd_Ready=0 throughout.
- SUB, A=8'h10, B=8'h20, Res_Ready held low 5 cycles -> ALU_Out=16'h00F0 and CarryOut=1 held stable with Res_Valid=1 and Cmd_Ready=0. Completes on the first edge with Res_Ready=1.
- Opcode 5'h1F -> ALU_Out=0, Err=1. Then ROR with A=8'h01 -> ALU_Out=16'h0080, Err=0.
- Reset_n pulsed low at the 4th MUL iteration -> outputs 0 immediately and Cmd_Ready=1 after release. A following ADD 8'h01+8'h01 returns 16'h0002.
- With ALU_DIV_EN: DIV, A=8'hE7, B=8'h98 -> ALU_Out=16'h4F01. DIV with B=0 -> 16'hFFFF and Err=1 after e1. Without the macro: opcode 12 -> ALU_Out=0, Err=1.

Source files
------------

// File: rtl/alu_cmd_responder_if.sv
// Command/result bus between an ALU command initiator and the
// alu_cmd_responder. The initiator drives the command half and Res_Ready.
// The responder drives Cmd_Ready and the result half.
interface alu_cmd_responder_if #(
    parameter int WIDTH = 8
);
    // Command half
    logic                   Cmd_Valid;
    logic                   Cmd_Ready;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [4:0]             Opcode;

    // Result half
    logic                   Res_Valid;
    logic                   Res_Ready;
    logic [2*WIDTH-1:0]     ALU_Out;
    logic                   CarryOut;
    logic                   Err;

    // Initiator side (bench or sequencer)
    modport master (
        output Cmd_Valid,
        output A,
        output B,
        output Opcode,
        output Res_Ready,
        input  Cmd_Ready,
        input  Res_Valid,
        input  ALU_Out,
        input  CarryOut,
        input  Err
    );

    // Responder side
    modport slave (
        input  Cmd_Valid,
        input  A,
        input  B,
        input  Opcode,
        input  Res_Ready,
        output Cmd_Ready,
        output Res_Valid,
        output ALU_Out,
        output CarryOut,
        output Err
    );
endinterface

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder: sequential responder for ALU commands.
// One command is accepted per Cmd_Valid/Cmd_Ready handshake.
// Logic and arithmetic ops complete one edge after acceptance.
// MUL runs WIDTH shift-add iterations.
// The result is offered on Res_Valid/Res_Ready and held until it is taken.
//
// Optional feature: define ALU_DIV_EN to enable opcode 12 (DIV).
// DIV is a WIDTH-iteration restoring divider that returns {remainder, quotient}.
// Divide-by-zero skips the iterations and returns all ones with Err set.
// Without ALU_DIV_EN, opcode 12 is treated like any other illegal opcode.
module alu_cmd_responder #(
    parameter int WIDTH = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    alu_cmd_responder_if.slave      bus
);

    localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_NOT = 5'd6;
    localparam logic [4:0] OP_SHL = 5'd7;
    localparam logic [4:0] OP_SHR = 5'd8;
    localparam logic [4:0] OP_ROL = 5'd9;
    localparam logic [4:0] OP_ROR = 5'd10;
    localparam logic [4:0] OP_CMP = 5'd11;
`ifdef ALU_DIV_EN
    localparam logic [4:0] OP_DIV = 5'd12;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MULT = 3'd2,
        S_DONE = 3'd3
`ifdef ALU_DIV_EN
        ,
        S_DIVS = 3'd4
`endif
    } state_t;

    // Control and latched operands
    state_t                 state_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [4:0]             op_q;
    logic [CNT_W-1:0]       cnt_q;

    // Iterative datapath: {high half, low half}.
    // For MUL this is {partial product, remaining multiplier}.
    // For DIV this is {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]     acc_q;

    // Registered outputs
    logic                   cmd_ready_q;
    logic                   res_valid_q;
    logic [2*WIDTH-1:0]     alu_out_q;
    logic                   carry_q;
    logic                   err_q;

    // Single-cycle result and next iteration values
    logic [WIDTH:0]         add_sum_s;
    logic [WIDTH:0]         sub_diff_s;
    logic [2*WIDTH-1:0]     alu_out_d;
    logic                   carry_d;
    logic                   err_d;
    logic [WIDTH:0]         mul_sum_s;
    logic [2*WIDTH-1:0]     mul_acc_d;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]         div_shift_s;
    logic [WIDTH:0]         div_diff_s;
    logic [2*WIDTH-1:0]     div_acc_d;
`endif

    assign bus.Cmd_Ready = cmd_ready_q;
    assign bus.Res_Valid = res_valid_q;
    assign bus.ALU_Out   = alu_out_q;
    assign bus.CarryOut  = carry_q;
    assign bus.Err       = err_q;

    // Single-cycle ALU result computed from the latched command
    always_comb begin
        add_sum_s  = {1'b0, a_q} + {1'b0, b_q};
        sub_diff_s = {1'b0, a_q} - {1'b0, b_q};
        alu_out_d  = {(2*WIDTH){1'b0}};
        carry_d    = 1'b0;
        err_d      = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_out_d = {{WIDTH{1'b0}}, add_sum_s[WIDTH-1:0]};
                carry_d   = add_sum_s[WIDTH];
            end
            OP_SUB: begin
                alu_out_d = {{WIDTH{1'b0}}, sub_diff_s[WIDTH-1:0]};
                // The borrow out of the extended subtraction is exactly A<B.
                carry_d   = sub_diff_s[WIDTH];
            end
            OP_AND: alu_out_d = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:  alu_out_d = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR: alu_out_d = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_NOT: alu_out_d = {{WIDTH{1'b0}}, ~a_q};
            OP_SHL: begin
                alu_out_d = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0};
                carry_d   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_out_d = {{WIDTH{1'b0}}, 1'b0, a_q[WIDTH-1:1]};
                carry_d   = a_q[0];
            end
            OP_ROL: alu_out_d = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], a_q[WIDTH-1]};
            OP_ROR: alu_out_d = {{WIDTH{1'b0}}, a_q[0], a_q[WIDTH-1:1]};
            OP_CMP: alu_out_d = {{(2*WIDTH-2){1'b0}}, (a_q > b_q), (a_q == b_q)};
`ifdef ALU_DIV_EN
            // EXEC sees DIV only for a zero divisor.
            OP_DIV: begin
                alu_out_d = {(2*WIDTH){1'b1}};
                err_d     = 1'b1;
            end
`endif
            default: begin
                alu_out_d = {(2*WIDTH){1'b0}};
                err_d     = 1'b1;
            end
        endcase
    end

    // One shift-add multiply step: conditionally add A to the high half, then shift right
    always_comb begin
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        mul_acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    // One restoring-division step: shift in the next dividend bit, then subtract B if it fits
    always_comb begin
        div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        // The partial remainder is below 2*B, so bit WIDTH of the difference is a clean borrow.
        if (!div_diff_s[WIDTH]) begin
            div_acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // Command/result FSM with registered handshake and result outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            op_q        <= 5'd0;
            cnt_q       <= {CNT_W{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            alu_out_q   <= {(2*WIDTH){1'b0}};
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Ready rises on the first edge after reset and stays up while idle.
                    cmd_ready_q <= 1'b1;
                    if (bus.Cmd_Valid && cmd_ready_q) begin
                        a_q         <= bus.A;
                        b_q         <= bus.B;
                        op_q        <= bus.Opcode;
                        cnt_q       <= {CNT_W{1'b0}};
                        cmd_ready_q <= 1'b0;
                        case (bus.Opcode)
                            OP_MUL: begin
                                acc_q   <= {{WIDTH{1'b0}}, bus.B};
                                state_q <= S_MULT;
                            end
`ifdef ALU_DIV_EN
                            OP_DIV: begin
                                acc_q <= {{WIDTH{1'b0}}, bus.A};
                                if (bus.B != {WIDTH{1'b0}}) begin
                                    state_q <= S_DIVS;
                                end else begin
                                    state_q <= S_EXEC;
                                end
                            end
`endif
                            default: begin
                                acc_q   <= {(2*WIDTH){1'b0}};
                                state_q <= S_EXEC;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    alu_out_q   <= alu_out_d;
                    carry_q     <= carry_d;
                    err_q       <= err_d;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_MULT: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        alu_out_q   <= mul_acc_d;
                        carry_q     <= 1'b0;
                        err_q       <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`ifdef ALU_DIV_EN
                S_DIVS: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        alu_out_q   <= div_acc_d;
                        carry_q     <= 1'b0;
                        err_q       <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    // The result registers keep their value until the next command overwrites them.
                    if (bus.Res_Ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed self-checking bench for alu_cmd_responder.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled at that point.
// Define ALU_DIV_EN to exercise DIV; otherwise opcode 12 is checked as illegal.
module tb_alu_cmd_responder;

    logic Clk;
    logic Reset_n;
    int   total;
    int   bad;

    alu_cmd_responder_if #(.WIDTH(8)) bus ();

    alu_cmd_responder #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present a command while Cmd_Ready is high, pass edge e0, then scramble the inputs.
    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        chk("ready_before_cmd", {31'd0, bus.Cmd_Ready}, 32'd1);
        bus.Cmd_Valid = 1'b1;
        bus.Opcode    = op;
        bus.A         = a;
        bus.B         = b;
        tick();
        bus.Cmd_Valid = 1'b0;
        bus.Opcode    = 5'h1F;
        bus.A         = 8'h5A;
        bus.B         = 8'hC3;
    endtask

    // Single-cycle op with Res_Ready high: check the result after e1, then retire it at e2.
    task automatic run1(input string tag, input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] eo, input logic ec,
                        input logic ee);
        bus.Res_Ready = 1'b1;
        issue(op, a, b);
        tick();
        chk({tag, "_valid"}, {31'd0, bus.Res_Valid}, 32'd1);
        chk({tag, "_out"},   {16'd0, bus.ALU_Out},   {16'd0, eo});
        chk({tag, "_carry"}, {31'd0, bus.CarryOut},  {31'd0, ec});
        chk({tag, "_err"},   {31'd0, bus.Err},       {31'd0, ee});
        tick();
        chk({tag, "_retired"}, {31'd0, bus.Res_Valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        Reset_n       = 1'b0;
        bus.Cmd_Valid = 1'b0;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.Opcode    = 5'd0;
        bus.Res_Ready = 1'b0;

        // Reset state
        #1;
        chk("rst_ready", {31'd0, bus.Cmd_Ready}, 32'd0);
        chk("rst_valid", {31'd0, bus.Res_Valid}, 32'd0);
        chk("rst_out",   {16'd0, bus.ALU_Out},   32'd0);
        chk("rst_carry", {31'd0, bus.CarryOut},  32'd0);
        chk("rst_err",   {31'd0, bus.Err},       32'd0);
        tick();
        tick();
        chk("rst_ready_held", {31'd0, bus.Cmd_Ready}, 32'd0);
        #2 Reset_n = 1'b1;
        tick();
        chk("ready_after_release", {31'd0, bus.Cmd_Ready}, 32'd1);

        // ADD E7+98: result after e1, Cmd_Ready back the cycle after the result is taken
        bus.Res_Ready = 1'b1;
        issue(5'd0, 8'hE7, 8'h98);
        chk("add_e0_valid", {31'd0, bus.Res_Valid}, 32'd0);
        chk("add_e0_ready", {31'd0, bus.Cmd_Ready}, 32'd0);
        tick();
        chk("add_valid", {31'd0, bus.Res_Valid}, 32'd1);
        chk("add_out",   {16'd0, bus.ALU_Out},   32'h0000_007F);
        chk("add_carry", {31'd0, bus.CarryOut},  32'd1);
        chk("add_err",   {31'd0, bus.Err},       32'd0);
        chk("add_busy",  {31'd0, bus.Cmd_Ready}, 32'd0);
        tick();
        chk("add_taken_valid", {31'd0, bus.Res_Valid}, 32'd0);
        chk("add_taken_ready", {31'd0, bus.Cmd_Ready}, 32'd1);

        // MUL E7*98 = 8928, exactly 8 edges after acceptance
        issue(5'd2, 8'hE7, 8'h98);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("mul_wait_valid", {31'd0, bus.Res_Valid}, 32'd0);
            chk("mul_wait_ready", {31'd0, bus.Cmd_Ready}, 32'd0);
        end
        tick();
        chk("mul_valid", {31'd0, bus.Res_Valid}, 32'd1);
        chk("mul_out",   {16'd0, bus.ALU_Out},   32'h0000_8928);
        chk("mul_carry", {31'd0, bus.CarryOut},  32'd0);
        chk("mul_err",   {31'd0, bus.Err},       32'd0);
        chk("mul_ready", {31'd0, bus.Cmd_Ready}, 32'd0);
        tick();
        chk("mul_retired", {31'd0, bus.Res_Valid}, 32'd0);

        // SUB 10-20 under 5 cycles of backpressure
        bus.Res_Ready = 1'b0;
        issue(5'd1, 8'h10, 8'h20);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("sub_hold_valid", {31'd0, bus.Res_Valid}, 32'd1);
            chk("sub_hold_out",   {16'd0, bus.ALU_Out},   32'h0000_00F0);
            chk("sub_hold_carry", {31'd0, bus.CarryOut},  32'd1);
            chk("sub_hold_ready", {31'd0, bus.Cmd_Ready}, 32'd0);
        end
        bus.Res_Ready = 1'b1;
        tick();
        chk("sub_taken_valid", {31'd0, bus.Res_Valid}, 32'd0);
        chk("sub_taken_ready", {31'd0, bus.Cmd_Ready}, 32'd1);

        // Illegal opcode, then ROR
        run1("illegal_1f", 5'h1F, 8'hAB, 8'hCD, 16'h0000, 1'b0, 1'b1);
        run1("ror",        5'd10, 8'h01, 8'h00, 16'h0080, 1'b0, 1'b0);

        // Remaining single-cycle opcodes and boundaries
        run1("add_wrap", 5'd0,  8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0);
        run1("sub_eq",   5'd1,  8'h42, 8'h42, 16'h0000, 1'b0, 1'b0);
        run1("and",      5'd3,  8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0);
        run1("or",       5'd4,  8'hF0, 8'h0C, 16'h00FC, 1'b0, 1'b0);
        run1("xor",      5'd5,  8'hAA, 8'hFF, 16'h0055, 1'b0, 1'b0);
        run1("not",      5'd6,  8'h0F, 8'h00, 16'h00F0, 1'b0, 1'b0);
        run1("shl",      5'd7,  8'h81, 8'h00, 16'h0002, 1'b1, 1'b0);
        run1("shr",      5'd8,  8'h81, 8'h00, 16'h0040, 1'b1, 1'b0);
        run1("rol",      5'd9,  8'h81, 8'h00, 16'h0003, 1'b0, 1'b0);
        run1("cmp_eq",   5'd11, 8'h05, 8'h05, 16'h0001, 1'b0, 1'b0);
        run1("cmp_gt",   5'd11, 8'h09, 8'h05, 16'h0002, 1'b0, 1'b0);
        run1("cmp_lt",   5'd11, 8'h03, 8'h05, 16'h0000, 1'b0, 1'b0);
        run1("illegal_d", 5'd13, 8'h01, 8'h01, 16'h0000, 1'b0, 1'b1);

`ifdef ALU_DIV_EN
        // DIV E7/98: quotient 01, remainder 4F, same latency as MUL
        issue(5'd12, 8'hE7, 8'h98);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("div_wait_valid", {31'd0, bus.Res_Valid}, 32'd0);
        end
        tick();
        chk("div_valid", {31'd0, bus.Res_Valid}, 32'd1);
        chk("div_out",   {16'd0, bus.ALU_Out},   32'h0000_4F01);
        chk("div_err",   {31'd0, bus.Err},       32'd0);
        tick();
        chk("div_retired", {31'd0, bus.Res_Valid}, 32'd0);
        run1("div_by_zero", 5'd12, 8'h37, 8'h00, 16'hFFFF, 1'b0, 1'b1);
`else
        run1("op12_illegal", 5'd12, 8'hE7, 8'h98, 16'h0000, 1'b0, 1'b1);
`endif

        // Reset pulsed during the 4th MUL iteration
        issue(5'd2, 8'hE7, 8'h98);
        tick();
        tick();
        tick();
        #2 Reset_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.Res_Valid}, 32'd0);
        chk("midrst_out",   {16'd0, bus.ALU_Out},   32'd0);
        chk("midrst_carry", {31'd0, bus.CarryOut},  32'd0);
        chk("midrst_err",   {31'd0, bus.Err},       32'd0);
        chk("midrst_ready", {31'd0, bus.Cmd_Ready}, 32'd0);
        tick();
        #2 Reset_n = 1'b1;
        tick();
        chk("midrst_ready_after", {31'd0, bus.Cmd_Ready}, 32'd1);
        chk("midrst_no_result",   {31'd0, bus.Res_Valid}, 32'd0);
        run1("add_after_rst", 5'd0, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
